// File: rtl/instruction_prefetch_unit.sv
// instruction_prefetch_unit: AXI-Lite sequential instruction fetch into a small PC-tagged FIFO with redirect flush.
// Define PREFETCH_BUS_ERROR_EN to store rresp[1] per entry and halt fetch after an erroring beat.
module instruction_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    input  logic            i_Enable,
    input  logic            i_Redirect,
    input  logic [XLEN-1:0] i_Redirect_PC,
    input  logic            i_Ready,
    output logic [XLEN-1:0] o_Instruction,
    output logic [XLEN-1:0] o_PC,
    output logic            o_Instruction_Valid,
    output logic            o_Fetch_Error,
    output logic [31:0]     s_axil_araddr,
    output logic            s_axil_arvalid,
    input  logic            s_axil_arready,
    input  logic [31:0]     s_axil_rdata,
    input  logic [1:0]      s_axil_rresp,
    input  logic            s_axil_rvalid,
    output logic            s_axil_rready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t          state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [XLEN-1:0] ins_mem [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     count_q, count_d;
    logic            drop_q, halt_q, arvalid_q, rready_q;
    logic [31:0]     araddr_q;
    logic            valid, beat, push, pop, err_in;

    assign valid   = count_q != '0;
    assign beat    = state_q == DATA && s_axil_rvalid;
    assign push    = beat && !drop_q && !i_Redirect;
    assign pop     = valid && i_Ready && !i_Redirect;
    assign count_d = i_Redirect ? '0 : count_q + (AW + 1)'(push) - (AW + 1)'(pop);

    assign o_Instruction_Valid = valid;
    assign o_Instruction       = valid ? ins_mem[rd_q] : '0;
    assign o_PC                = valid ? pc_mem[rd_q] : '0;
    assign s_axil_araddr       = araddr_q;
    assign s_axil_arvalid      = arvalid_q;
    assign s_axil_rready       = rready_q;

`ifdef PREFETCH_BUS_ERROR_EN
    logic err_mem [DEPTH];
    assign err_in        = s_axil_rresp[1];
    assign o_Fetch_Error = valid & err_mem[rd_q];
    always_ff @(posedge i_Clock)
        if (push) err_mem[wr_q] <= err_in;
`else
    logic unused_rresp;
    assign unused_rresp  = ^s_axil_rresp;
    assign err_in        = 1'b0;
    assign o_Fetch_Error = 1'b0;
`endif

    always_ff @(posedge i_Clock)
        if (push) begin
            pc_mem[wr_q]  <= fetch_pc_q;
            ins_mem[wr_q] <= s_axil_rdata;
        end

    // Issue only from IDLE, so count < DEPTH there already accounts for the single in-flight slot.
    always_ff @(posedge i_Clock or posedge i_Reset)
        if (i_Reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            drop_q     <= 1'b0;
            halt_q     <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            araddr_q   <= '0;
        end else begin
            count_q    <= count_d;
            wr_q       <= i_Redirect ? '0 : wr_q + AW'(push);
            rd_q       <= i_Redirect ? '0 : rd_q + AW'(pop);
            fetch_pc_q <= i_Redirect ? (i_Redirect_PC & ~XLEN'(3)) : push ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
            halt_q     <= i_Redirect ? 1'b0 : halt_q | (push & err_in);
            if (i_Redirect && (state_q == ADDR || (state_q == DATA && !s_axil_rvalid)))
                drop_q <= 1'b1;
            else if (beat)
                drop_q <= 1'b0;
            case (state_q)
                IDLE: if (i_Enable && !halt_q && count_q < FULL && !i_Redirect) begin
                    state_q   <= ADDR;
                    arvalid_q <= 1'b1;
                    araddr_q  <= fetch_pc_q[31:0] & ~32'd3;
                end
                ADDR: if (s_axil_arready) begin
                    state_q   <= DATA;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                end
                DATA: if (s_axil_rvalid) begin
                    state_q  <= IDLE;
                    rready_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// tb_instruction_prefetch_unit: directed plus random fetch/redirect traffic checked against a PC-sequence scoreboard.
module tb_instruction_prefetch_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        i_Enable = 1'b0, i_Redirect = 1'b0, i_Ready = 1'b0;
    logic [31:0] i_Redirect_PC = '0;
    logic [31:0] o_Instruction, o_PC, s_axil_araddr, s_axil_rdata = '0;
    logic        o_Instruction_Valid, o_Fetch_Error, s_axil_arvalid, s_axil_rready;
    logic        s_axil_arready = 1'b0, s_axil_rvalid = 1'b0;
    logic [1:0]  s_axil_rresp = '0;

    instruction_prefetch_unit dut (
        .i_Clock(clk), .i_Reset(rst), .i_Enable(i_Enable), .i_Redirect(i_Redirect),
        .i_Redirect_PC(i_Redirect_PC), .i_Ready(i_Ready), .o_Instruction(o_Instruction),
        .o_PC(o_PC), .o_Instruction_Valid(o_Instruction_Valid), .o_Fetch_Error(o_Fetch_Error),
        .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0, pops = 0;
    int          ar_pct = 100, r_pct = 100;
    logic        rpend = 1'b0, prev_stall = 1'b0, prev_rdr = 1'b0, trig = 1'b0, fired = 1'b0;
    logic [31:0] raddr = '0, prev_addr = '0, exp_pc = '0, old;
    logic [31:0] hs_q[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic exp_err(input logic [31:0] pc);
`ifdef PREFETCH_BUS_ERROR_EN
        return pc == 32'h20;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: slave drive and checks at negedge, slave/model update just after posedge.
    task automatic cycle();
        logic ar_hs, r_hs;
        logic [31:0] addr_s;
        @(negedge clk);
        s_axil_arready = $urandom_range(99) < ar_pct;
        s_axil_rvalid  = rpend && ($urandom_range(99) < r_pct);
        s_axil_rdata   = mem(raddr);
`ifdef PREFETCH_BUS_ERROR_EN
        s_axil_rresp   = raddr == 32'h20 ? 2'b10 : 2'b00;
`else
        s_axil_rresp   = 2'($urandom_range(3));
`endif
        if (trig && s_axil_rvalid && s_axil_rready && o_Instruction_Valid) begin
            i_Redirect = 1'b1;
            i_Redirect_PC = 32'h200;
            i_Ready = 1'b1;
            trig = 1'b0;
            fired = 1'b1;
        end
        if (prev_stall) chk("ar_hold", {s_axil_arvalid, s_axil_araddr}, {1'b1, prev_addr});
        if (s_axil_arvalid) chk("one_outstanding", rpend, 0);
        if (prev_rdr) chk("valid_after_redirect", o_Instruction_Valid, 0);
        if (o_Instruction_Valid) chk("fetch_err", o_Fetch_Error, exp_err(o_PC));
        else chk("idle_err", o_Fetch_Error, 0);
        if (o_Instruction_Valid && i_Ready && !i_Redirect) begin
            chk("pop_pc", o_PC, exp_pc);
            chk("pop_instr", o_Instruction, mem(exp_pc));
            exp_pc += 32'd4;
            pops++;
        end
        ar_hs = s_axil_arvalid && s_axil_arready;
        r_hs = s_axil_rvalid && s_axil_rready;
        addr_s = s_axil_araddr;
        prev_stall = s_axil_arvalid && !s_axil_arready;
        prev_addr = s_axil_araddr;
        prev_rdr = i_Redirect;
        @(posedge clk);
        #1;
        if (ar_hs) begin
            rpend = 1'b1;
            raddr = addr_s;
            hs_q.push_back(addr_s);
        end
        if (r_hs) rpend = 1'b0;
        if (prev_rdr) exp_pc = i_Redirect_PC & ~32'd3;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic redirect(input logic [31:0] pc);
        i_Redirect = 1'b1;
        i_Redirect_PC = pc;
        cycle();
        i_Redirect = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", o_Instruction_Valid, 0);
        chk("rst_arvalid", s_axil_arvalid, 0);
        chk("rst_araddr", s_axil_araddr, 0);
        chk("rst_rready", s_axil_rready, 0);
        chk("rst_pc_instr", {o_PC, o_Instruction}, 0);
        chk("rst_err", o_Fetch_Error, 0);
        rst = 1'b0;
        i_Enable = 1'b1;
        i_Ready = 1'b1;
        run(12);
        chk("seq_count", hs_q.size() >= 3, 1);
        chk("seq_a0", hs_q[0], 32'h0);
        chk("seq_a1", hs_q[1], 32'h4);
        chk("seq_a2", hs_q[2], 32'h8);
        i_Enable = 1'b0;
        run(8);
        hs_q.delete();
        i_Enable = 1'b1;
        i_Ready = 1'b0;
        run(30);
        chk("full_issued", hs_q.size(), 4);
        chk("full_arvalid", s_axil_arvalid, 0);
        i_Ready = 1'b1;
        cycle();
        i_Ready = 1'b0;
        run(10);
        chk("refill_issued", hs_q.size(), 5);
        i_Ready = 1'b1;
        ar_pct = 0;
        for (int i = 0; i < 20 && !s_axil_arvalid; i++) cycle();
        chk("stall_arvalid", s_axil_arvalid, 1);
        old = s_axil_araddr;
        hs_q.delete();
        cycle();
        redirect(32'h103);
        cycle();
        chk("stall_addr", s_axil_araddr, old);
        ar_pct = 100;
        run(15);
        chk("stall_old_hs", hs_q[0], old);
        chk("stall_new_hs", hs_q[1], 32'h100);
        i_Ready = 1'b0;
        run(8);
        trig = 1'b1;
        for (int i = 0; i < 30 && !fired; i++) begin
            cycle();
            i_Redirect = 1'b0;
        end
        chk("rvalid_redirect_fired", fired, 1);
        i_Ready = 1'b1;
        hs_q.delete();
        run(12);
        chk("rvalid_redirect_next", hs_q[0], 32'h200);
        redirect(32'hFFFF_FFF8);
        hs_q.delete();
        run(15);
        chk("wrap_addr", hs_q[2], 32'h0);
`ifdef PREFETCH_BUS_ERROR_EN
        i_Ready = 1'b0;
        redirect(32'h18);
        hs_q.delete();
        run(30);
        chk("err_halt_count", hs_q.size(), 3);
        chk("err_halt_arvalid", s_axil_arvalid, 0);
        i_Ready = 1'b1;
        run(10);
        chk("err_halt_after_drain", hs_q.size(), 3);
`endif
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                ar_pct = 30 + $urandom_range(70);
                r_pct = 30 + $urandom_range(70);
            end
            i_Enable = $urandom_range(9) != 0;
            i_Ready = $urandom_range(2) != 0;
            i_Redirect = $urandom_range(24) == 0;
            case ($urandom_range(2))
                0: i_Redirect_PC = $urandom;
                1: i_Redirect_PC = 32'hFFFF_FFF0 + 32'($urandom_range(15));
                default: i_Redirect_PC = 32'($urandom_range(255));
            endcase
            cycle();
        end
        chk("progress", pops > 300, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
